// File: rtl/mdu_hilo.sv
// mdu_hilo: iterative MIPS multiply/divide unit owning the HI/LO registers.
// MULT/MULTU use 32 shift-add steps, DIV/DIVU use 32 restoring-division
// steps; every add/subtract goes through a mdu_cla32 instance.

// 32-bit carry-lookahead adder: 4-bit groups with group generate/propagate.
module mdu_cla32 (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        cin_i,
    output logic [31:0] sum_o,
    output logic        cout_o
);
    logic [31:0] g_s;
    logic [31:0] p_s;
    logic [32:0] c_s;

    assign g_s = a_i & b_i;
    assign p_s = a_i ^ b_i;

    // Carry network: ripple inside a group, lookahead across group boundaries.
    always_comb begin
        c_s    = 33'd0;
        c_s[0] = cin_i;
        for (int j = 0; j < 8; j++) begin
            for (int k = 0; k < 3; k++) begin
                c_s[4*j+k+1] = g_s[4*j+k] | (p_s[4*j+k] & c_s[4*j+k]);
            end
            c_s[4*j+4] = g_s[4*j+3]
                       | (p_s[4*j+3] & g_s[4*j+2])
                       | (p_s[4*j+3] & p_s[4*j+2] & g_s[4*j+1])
                       | (p_s[4*j+3] & p_s[4*j+2] & p_s[4*j+1] & g_s[4*j])
                       | (p_s[4*j+3] & p_s[4*j+2] & p_s[4*j+1] & p_s[4*j] & c_s[4*j]);
        end
    end

    assign sum_o  = p_s ^ c_s[31:0];
    assign cout_o = c_s[32];
endmodule

module mdu_hilo #(
    parameter int ITER = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        hi_we_i,
    input  logic        lo_we_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_CALC = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [4:0] LAST_CNT = 5'(ITER - 1);

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] bm_q, bm_d;          // |b| (or b for unsigned ops)
    logic [31:0] acc_hi_q, acc_hi_d;  // P_hi for multiply, R for divide
    logic [31:0] acc_lo_q, acc_lo_d;  // P_lo for multiply, Q for divide
    logic        sq_q, sq_d;          // product / quotient sign
    logic        sr_q, sr_d;          // remainder sign
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    // Iteration adder and the two chained negation adders.
    logic [31:0] it_a_s, it_b_s, it_sum_s;
    logic        it_cin_s, it_c_s;
    logic [31:0] nl_a_s, nl_sum_s;
    logic        nl_c_s;
    logic [31:0] nh_a_s, nh_sum_s;
    logic        nh_cin_s, nh_cout_unused_s;

    // R never exceeds the divisor, so 32 stored bits suffice; the
    // shifted remainder needs the 33rd bit only transiently.
    logic [32:0] r_sh_s;
    logic [31:0] q_sh_s;
    logic        trial_ok_s;
    logic        signed_op_s;
    logic        add_c_s;
    logic [31:0] add_s_s;

    mdu_cla32 u_iter (.a_i(it_a_s), .b_i(it_b_s), .cin_i(it_cin_s),
                      .sum_o(it_sum_s), .cout_o(it_c_s));
    mdu_cla32 u_neg_lo (.a_i(nl_a_s), .b_i(32'd0), .cin_i(1'b1),
                        .sum_o(nl_sum_s), .cout_o(nl_c_s));
    mdu_cla32 u_neg_hi (.a_i(nh_a_s), .b_i(32'd0), .cin_i(nh_cin_s),
                        .sum_o(nh_sum_s), .cout_o(nh_cout_unused_s));

    assign signed_op_s = ~op_q[0];
    assign r_sh_s      = {acc_hi_q, acc_lo_q[31]};
    assign q_sh_s      = {acc_lo_q[30:0], 1'b0};
    // 33-bit trial R - |b| is non-negative when its carry out of bit 32 is set.
    assign trial_ok_s  = r_sh_s[32] | it_c_s;

    // Adder operand steering: iteration adder per op, negation adders per state.
    always_comb begin
        it_a_s   = acc_hi_q;
        it_b_s   = bm_q;
        it_cin_s = 1'b0;
        if (op_q[1]) begin
            it_a_s   = r_sh_s[31:0];
            it_b_s   = ~bm_q;
            it_cin_s = 1'b1;
        end else begin
            it_a_s   = acc_hi_q;
            it_b_s   = bm_q;
            it_cin_s = 1'b0;
        end
        nl_a_s   = ~acc_lo_q;
        nh_a_s   = ~acc_hi_q;
        nh_cin_s = 1'b1;
        if (state_q == S_PREP) begin
            nl_a_s = ~a_q;
            nh_a_s = ~b_q;
        end else begin
            nl_a_s = ~acc_lo_q;
            nh_a_s = ~acc_hi_q;
        end
        // 64-bit product negation chains the low adder's carry into the high one.
        if ((state_q == S_FIX) && !op_q[1]) begin
            nh_cin_s = nl_c_s;
        end else begin
            nh_cin_s = 1'b1;
        end
    end

    // Multiply step: conditional add of |b| into P_hi.
    always_comb begin
        add_c_s = 1'b0;
        add_s_s = acc_hi_q;
        if (acc_lo_q[0]) begin
            add_c_s = it_c_s;
            add_s_s = it_sum_s;
        end else begin
            add_c_s = 1'b0;
            add_s_s = acc_hi_q;
        end
    end

    // FSM next state and iteration counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d = S_PREP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PREP: begin
                state_d = S_CALC;
                cnt_d   = 5'd0;
            end
            S_CALC: begin
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == LAST_CNT) begin
                    state_d = S_FIX;
                end else begin
                    state_d = S_CALC;
                end
            end
            S_FIX:   state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values: operand latch, prep, iterations, fix-up, MTHI/MTLO.
    always_comb begin
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        bm_d     = bm_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        sq_d     = sq_q;
        sr_d     = sr_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    op_d = op_i;
                    a_d  = a_i;
                    b_d  = b_i;
                end else begin
                    op_d = op_q;
                end
                if (hi_we_i) begin
                    hi_d = wdata_i;
                end else begin
                    hi_d = hi_q;
                end
                if (lo_we_i) begin
                    lo_d = wdata_i;
                end else begin
                    lo_d = lo_q;
                end
            end
            S_PREP: begin
                bm_d     = (signed_op_s && b_q[31]) ? nh_sum_s : b_q;
                acc_lo_d = (signed_op_s && a_q[31]) ? nl_sum_s : a_q;
                acc_hi_d = 32'd0;
                sq_d     = signed_op_s & (a_q[31] ^ b_q[31]);
                sr_d     = signed_op_s & a_q[31];
            end
            S_CALC: begin
                if (!op_q[1]) begin
                    acc_hi_d = {add_c_s, add_s_s[31:1]};
                    acc_lo_d = {add_s_s[0], acc_lo_q[31:1]};
                end else if (trial_ok_s) begin
                    acc_hi_d = it_sum_s;
                    acc_lo_d = {q_sh_s[31:1], 1'b1};
                end else begin
                    acc_hi_d = r_sh_s[31:0];
                    acc_lo_d = q_sh_s;
                end
            end
            S_FIX: begin
                if (!op_q[1]) begin
                    hi_d = sq_q ? nh_sum_s : acc_hi_q;
                    lo_d = sq_q ? nl_sum_s : acc_lo_q;
                end else if (b_q == 32'd0) begin
                    hi_d = a_q;
                    lo_d = 32'hFFFF_FFFF;
                end else begin
                    hi_d = sr_q ? nh_sum_s : acc_hi_q;
                    lo_d = sq_q ? nl_sum_s : acc_lo_q;
                end
            end
            default: begin
                hi_d = hi_q;
            end
        endcase
        busy_d = (state_d == S_PREP) || (state_d == S_CALC) || (state_d == S_FIX);
        done_d = (state_d == S_DONE);
    end

    // State, datapath and registered outputs with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= 5'd0;
            op_q     <= 2'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            bm_q     <= 32'd0;
            acc_hi_q <= 32'd0;
            acc_lo_q <= 32'd0;
            sq_q     <= 1'b0;
            sr_q     <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            bm_q     <= bm_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            sq_q     <= sq_d;
            sr_q     <= sr_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;
endmodule

// File: doc/mdu_hilo.md
# mdu_hilo

Multi-cycle multiply/divide unit for the MIPS execute stage. It owns the architectural HI/LO registers and executes MULT, MULTU, DIV and DIVU iteratively. Each iteration drives one 32-bit CLA32 adder and consumes its sum and carry-out. Sign handling, divide-by-zero policy and MTHI/MTLO writes are all handled here, so the pipeline only needs `busy` to stall and `done` to observe completion.

## Interface
- `ITER`, 32: iteration count. Fixed at 32; no other value is supported.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  launch operation; sampled only when `busy`=0.
- `op`  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a`  in  32  rs operand (multiplicand / dividend); sampled with `start`.
- `b`  in  32  rt operand (multiplier / divisor); sampled with `start`.
- `hi_we`  in  1  MTHI write enable.
- `lo_we`  in  1  MTLO write enable.
- `wdata`  in  32  MTHI/MTLO data.
- `busy`  out  1  operation in flight; pipeline stalls on it.
- `done`  out  1  one-cycle pulse; HI/LO hold the new result in this cycle.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- States: IDLE, PREP, CALC, FIX, DONE.
- Reset (any state, including mid-operation) forces IDLE.
  - `busy`=0, `done`=0, `hi`=0, `lo`=0.
  - The iteration counter clears and no writeback occurs.
- IDLE or DONE with `start`=1:
  - Latch `op`, `a`, `b`; go to PREP.
  - `start` is ignored in PREP, CALC and FIX.
- PREP (1 cycle):
  - Signed ops: take magnitudes |a| and |b|.
  - Record the result signs: quotient/product sign = a[31]^b[31]; remainder sign = a[31].
  - Unsigned ops: operands are used as-is.
- CALC (exactly 32 cycles; counter runs 0..31):
  - Multiply: shift-add on {P_hi, P_lo}, initialised to {0, |a|}.
    - If P_lo[0]=1: {c, s} = CLA32(P_hi, |b|, 0); otherwise {c, s} = {0, P_hi}.
    - Then {P_hi, P_lo} ← {c, s, P_lo} >> 1.
  - Divide: restoring division on remainder R (33-bit, initial 0) and quotient Q (initial |a|).
    - Shift {R, Q} left 1.
    - Trial subtract via CLA32(R[31:0], ~|b|, 1), combined with R[32].
    - Non-negative trial: commit it and set Q[0]=1. Negative trial: restore R and set Q[0]=0.
- FIX (1 cycle): writes HI/LO at the end of the cycle.
  - Multiply: if the sign is negative, take the 64-bit two's-complement negation (two chained CLA32). HI = upper word, LO = lower word.
  - Divide: LO = quotient, negated if the quotient sign is 1. HI = remainder, negated if the remainder sign is 1.
  - Divide by zero (latched `b`=0, DIV or DIVU): LO = 32'hFFFFFFFF, HI = latched `a`. Latency is unchanged.
  - DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0. Produces no exception or flag.
- DONE (1 cycle): `done`=1, `busy`=0.
  - Returns to IDLE, or to PREP if `start`=1.
- MTHI/MTLO:
  - When `busy`=0: `hi_we`/`lo_we` update `hi`/`lo` from `wdata` at the next edge.
  - When `busy`=1: writes are ignored.
  - A write and `start` in the same cycle both take effect; the operation result later overwrites HI/LO.
- All add/subtract in the datapath goes through CLA32 instances; there is no behavioural `+`/`-`.

## Timing
- `start` high in cycle k (unit idle):
  - PREP in cycle k+1.
  - CALC in cycles k+2..k+33.
  - FIX in cycle k+34.
  - `done`=1 in cycle k+35, with new `hi`/`lo` visible in that same cycle.
- `busy`=1 in cycles k+1..k+34; `busy`=0 in cycle k+35.
- Back-to-back: `start` in the DONE cycle launches the next operation with the same 35-cycle latency.
- Latency is fixed for all ops, operands and divide-by-zero; there is no early termination.
- `hi`/`lo` keep their prior values throughout PREP/CALC and change only at the FIX→DONE edge.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF, start at cycle k -> `done` at k+35; HI=0xFFFFFFFE, LO=0x00000001; `busy` high exactly k+1..k+34.
- MULT a=0xFFFFFFFD (-3), b=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. MULT a=0x80000000, b=0x80000000 -> HI=0x40000000, LO=0.
- DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=7, b=2 -> LO=3, HI=1.
- DIVU a=0x12345678, b=0 -> LO=0xFFFFFFFF, HI=0x12345678 at k+35. DIV a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0.
- Start DIVU, assert `rst` in CALC cycle 10 -> next cycle `busy`=0, `hi`=`lo`=0, no `done` pulse. Also check: `start` pulses while busy are ignored; `hi_we`=1 while busy leaves HI unchanged.
- Idle `lo_we`=1, wdata=0xCAFEBABE -> LO=0xCAFEBABE next cycle. Then MULTU 3×5, with `start` held through the DONE cycle for a second MULTU 2×2 -> done pulses at k+35 and k+70; final LO=4, HI=0.
